jtag_master: RTL and testbench

JTAG_MASTER -- requirements
Module: jtag_master

---
 rtl/jtag_pkg.sv | 40 ++++
 rtl/jtag_tck_gen.sv | 43 ++++
 rtl/jtag_master.sv | 153 +++++++++++++++
 tb/tb_jtag_master.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtag_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// jtag_pkg : state encoding and TMS sequence tables shared by jtag_master
// Rev 1.0
// ----------------------------------------------------------------------------
package jtag_pkg;

  typedef enum logic [2:0] {
    RESET_SEQ = 3'd0,
    IDLE      = 3'd1,
    PRE       = 3'd2,
    SHIFT     = 3'd3,
    POST      = 3'd4
  } jtag_state_t;

  localparam int RESET_SEQ_LEN = 6;
  localparam int PRE_IR_LEN    = 4;
  localparam int PRE_DR_LEN    = 3;
  localparam int POST_LEN      = 2;

  // Tables are read LSB first, one bit per tck of the phase.
  localparam logic [15:0] RESET_TMS  = 16'h001F;  // 1,1,1,1,1,0
  localparam logic [15:0] PRE_IR_TMS = 16'h0003;  // 1,1,0,0
  localparam logic [15:0] PRE_DR_TMS = 16'h0001;  // 1,0,0
  localparam logic [15:0] POST_TMS   = 16'h0001;  // 1,0

  function automatic logic tms_bit(input jtag_state_t st, input logic ir, input logic [3:0] idx);
    logic [15:0] tbl;
    tbl = '0;
    case (st)
      RESET_SEQ: tbl = RESET_TMS;
      PRE:       tbl = ir ? PRE_IR_TMS : PRE_DR_TMS;
      POST:      tbl = POST_TMS;
      default:   tbl = '0;
    endcase
    return tbl[idx];
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_tck_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// jtag_tck_gen : tck divider (low half then high half) with edge strobes
// Rev 1.0
// ----------------------------------------------------------------------------
module jtag_tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tck,
  output logic rise,
  output logic fall
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          at_end;

  assign at_end = (cnt == CW'(CLK_DIV - 1));
  // Strobes flag the clk edge on which tck itself toggles.
  assign rise   = en && at_end && !tck;
  assign fall   = en && at_end && tck;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (!en) begin
      cnt <= '0;
      tck <= 1'b0;
    end else if (at_end) begin
      cnt <= '0;
      tck <= !tck;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/jtag_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// jtag_master : IR/DR scan engine driving a JTAG TAP from Run-Test/Idle
// Option macro JTAG_MASTER_RESET_CMD_EN enables cmd_reset TAP-reset commands.
// Rev 1.0
// ----------------------------------------------------------------------------
module jtag_master
  import jtag_pkg::*;
#(
  parameter int REGISTER_WIDTH = 8,
  parameter int CLK_DIV        = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_ir,
  input  logic                      cmd_reset,
  input  logic [REGISTER_WIDTH-1:0] cmd_data,
  output logic                      rsp_valid,
  output logic [REGISTER_WIDTH-1:0] rsp_data,
  output logic                      tck,
  output logic                      tms,
  output logic                      tdi,
  input  logic                      tdo
);

  localparam int CNT_W = $clog2(REGISTER_WIDTH + 8);

  jtag_state_t               state;
  logic [CNT_W-1:0]          cnt;
  logic                      ir_r;
  logic [REGISTER_WIDTH-1:0] data_r;
  logic [REGISTER_WIDTH-1:0] data_next;
  logic [REGISTER_WIDTH-1:0] cap;
  logic                      last;
  logic                      tck_en;
  logic                      rise;
  logic                      fall;

`ifndef JTAG_MASTER_RESET_CMD_EN
  logic unused_cmd_reset;
  assign unused_cmd_reset = cmd_reset;
`endif

  assign tck_en    = (state != IDLE);
  assign data_next = data_r >> 1;

  jtag_tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk   (clk),
    .reset (reset),
    .en    (tck_en),
    .tck   (tck),
    .rise  (rise),
    .fall  (fall)
  );

  always_comb begin
    last = 1'b0;
    case (state)
      RESET_SEQ: last = (cnt == CNT_W'(RESET_SEQ_LEN - 1));
      PRE:       last = (cnt == (ir_r ? CNT_W'(PRE_IR_LEN - 1) : CNT_W'(PRE_DR_LEN - 1)));
      SHIFT:     last = (cnt == CNT_W'(REGISTER_WIDTH - 1));
      POST:      last = (cnt == CNT_W'(POST_LEN - 1));
      default:   last = 1'b0;
    endcase
  end

  // tms/tdi for the next tck period are set on the falling edge that ends the current one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RESET_SEQ;
      cnt       <= '0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      ir_r      <= 1'b0;
      data_r    <= '0;
      cap       <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          tms <= 1'b0;
          tdi <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            cnt       <= '0;
            ir_r      <= cmd_ir;
            data_r    <= cmd_data;
`ifdef JTAG_MASTER_RESET_CMD_EN
            if (cmd_reset) begin
              state <= RESET_SEQ;
              tms   <= tms_bit(RESET_SEQ, 1'b0, 4'd0);
            end else begin
              state <= PRE;
              tms   <= tms_bit(PRE, cmd_ir, 4'd0);
            end
`else
            state <= PRE;
            tms   <= tms_bit(PRE, cmd_ir, 4'd0);
`endif
          end
        end
        default: begin
          if (rise && state == SHIFT) cap <= {tdo, cap[REGISTER_WIDTH-1:1]};
          if (fall) begin
            if (!last) begin
              cnt <= cnt + 1'b1;
              if (state == SHIFT) begin
                data_r <= data_next;
                tdi    <= data_next[0];
                tms    <= (cnt == CNT_W'(REGISTER_WIDTH - 2));
              end else begin
                tms <= tms_bit(state, ir_r, cnt[3:0] + 4'd1);
              end
            end else begin
              cnt <= '0;
              case (state)
                PRE: begin
                  state <= SHIFT;
                  tdi   <= data_r[0];
                  tms   <= (REGISTER_WIDTH == 1);
                end
                SHIFT: begin
                  state <= POST;
                  tdi   <= 1'b0;
                  tms   <= tms_bit(POST, ir_r, 4'd0);
                end
                POST: begin
                  state     <= IDLE;
                  tms       <= 1'b0;
                  cmd_ready <= 1'b1;
                  rsp_valid <= 1'b1;
                  rsp_data  <= cap;
                end
                default: begin
                  state     <= IDLE;
                  tms       <= 1'b0;
                  cmd_ready <= 1'b1;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jtag_master.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_jtag_master : directed scans against a behavioural TAP target, scoreboarded rsp
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_jtag_master;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_ir = 1'b0;
  logic       cmd_reset = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       tck, tms, tdi, tdo;

  jtag_master #(.REGISTER_WIDTH(8), .CLK_DIV(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_ir    (cmd_ir),
    .cmd_reset (cmd_reset),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .tck       (tck),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Behavioural TAP target
  localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4, EX1DR = 5, PAUDR = 6, EX2DR = 7,
                 UPDR = 8, SELIR = 9, CAPIR = 10, SHIR = 11, EX1IR = 12, PAUIR = 13, EX2IR = 14, UPIR = 15;

  function automatic int tap_next(input int s, input logic m);
    case (s)
      TLR:   return m ? TLR   : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR  : PAUDR;
      PAUDR: return m ? EX2DR : PAUDR;
      EX2DR: return m ? UPDR  : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR   : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR  : PAUIR;
      PAUIR: return m ? EX2IR : PAUIR;
      EX2IR: return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  int          tap = TLR;
  logic [7:0]  sr = 8'h00;
  logic [7:0]  tgt_pattern = 8'h00;
  logic        tdo_model = 1'b0;
  logic        tdo_tie = 1'b0;
  int          tck_total = 0;
  logic [63:0] tms_hist = '0;
  logic [63:0] tdi_hist = '0;
  logic [7:0]  tgt_in_q[$];
  logic [7:0]  exp_q[$];

  assign tdo = tdo_tie ? 1'b1 : tdo_model;

  always @(posedge tck) begin
    tck_total++;
    tms_hist = {tms_hist[62:0], tms};
    tdi_hist = {tdi_hist[62:0], tdi};
    if (tap == CAPDR || tap == CAPIR) sr = tgt_pattern;
    else if (tap == SHDR || tap == SHIR) begin
      sr = {tdi, sr[7:1]};
      if (tms) tgt_in_q.push_back(sr);
    end
    tap = tap_next(tap, tms);
  end

  always @(negedge tck) tdo_model <= (tap == SHDR || tap == SHIR) ? sr[0] : 1'b0;

  // Response monitor
  logic       rv_prev = 1'b0;
  logic [7:0] exp_rsp;
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (rv_prev) check("rsp_pulse_width", {63'd0, rv_prev}, 64'd0);
      if (exp_q.size() == 0) check("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
      else begin
        exp_rsp = exp_q.pop_front();
        check("rsp_data", {56'd0, rsp_data}, {56'd0, exp_rsp});
        check("rsp_with_ready", {63'd0, cmd_ready}, 64'd1);
      end
    end
    rv_prev = rsp_valid;
  end

  function automatic logic [63:0] last_n(input logic [63:0] h, input int n);
    return h & ((64'd1 << n) - 64'd1);
  endfunction

  task automatic wait_ready(output int cyc);
    cyc = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      cyc++;
      if (cmd_ready) break;
    end
    if (!cmd_ready) check("ready_timeout", {63'd0, cmd_ready}, 64'd1);
  endtask

  task automatic check_tgt(input string name, input logic [7:0] d);
    if (tgt_in_q.size() > 0) check(name, {56'd0, tgt_in_q.pop_front()}, {56'd0, d});
    else check({name, "_missing"}, 64'(tgt_in_q.size()), 64'd1);
  endtask

  task automatic do_scan(input logic ir, input logic rc, input logic [7:0] d,
                         input logic [7:0] pat, input logic tie, output int ntck);
    int cyc, t0;
    tgt_pattern = pat;
    tdo_tie     = tie;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ir = ir; cmd_reset = rc; cmd_data = d;
    t0 = tck_total;
    @(negedge clk);
    check("accepted", {63'd0, cmd_ready}, 64'd0);
    cmd_valid = 1'b0; cmd_reset = 1'b0; cmd_data = 8'h00;
    wait_ready(cyc);
    ntck = tck_total - t0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, ntck, t0;

    // Reset state and power-up RESET_SEQ
    repeat (3) @(negedge clk);
    check("rst_tck", {63'd0, tck}, 64'd0);
    check("rst_tms", {63'd0, tms}, 64'd1);
    check("rst_tdi", {63'd0, tdi}, 64'd0);
    check("rst_ready", {63'd0, cmd_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_data", {56'd0, rsp_data}, 64'd0);
    t0 = tck_total;
    reset = 1'b0;
    wait_ready(cyc);
    check("rstseq_ready_cycles", 64'(cyc), 64'd24);
    check("rstseq_tck", 64'(tck_total - t0), 64'd6);
    check("rstseq_tms", last_n(tms_hist, 6), 64'h3E);
    check("rstseq_tap", 64'(tap), 64'(RTI));

    // IR scan A5, target captures 3C
    exp_q.push_back(8'h3C);
    do_scan(1'b1, 1'b0, 8'hA5, 8'h3C, 1'b0, ntck);
    check("ir_tck", 64'(ntck), 64'd14);
    check("ir_tms", last_n(tms_hist, 14), 64'h3006);
    check("ir_tdi", last_n(tdi_hist, 14), 64'h0294);
    check("ir_tap", 64'(tap), 64'(RTI));
    check_tgt("ir_tgt", 8'hA5);
    check("idle_tms", {63'd0, tms}, 64'd0);

    // DR scan 01 with tdo tied high
    exp_q.push_back(8'hFF);
    do_scan(1'b0, 1'b0, 8'h01, 8'h00, 1'b1, ntck);
    check("dr_tck", 64'(ntck), 64'd13);
    check("dr_tms", last_n(tms_hist, 13), 64'h1006);
    check("dr_tdi", last_n(tdi_hist, 13), 64'h0200);
    check_tgt("dr_tgt", 8'h01);

    // cmd_valid held with changing data; second command taken on the IDLE cycle
    tgt_pattern = 8'h96;
    tdo_tie     = 1'b0;
    exp_q.push_back(8'h96);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ir = 1'b0; cmd_data = 8'h5A;
    t0 = tck_total;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (cmd_ready) begin
        cmd_ir = 1'b1; cmd_data = 8'hC3;
        exp_q.push_back(8'h96);
        break;
      end
      if (k == 5) check("rsp_hold", {56'd0, rsp_data}, 64'hFF);
      cmd_data = 8'(k * 37 + 11);
      cmd_ir   = k[0];
    end
    @(negedge clk);
    check("b2b_accepted", {63'd0, cmd_ready}, 64'd0);
    cmd_valid = 1'b0;
    wait_ready(cyc);
    check("b2b_tck", 64'(tck_total - t0), 64'd27);
    check_tgt("b2b_tgt0", 8'h5A);
    check_tgt("b2b_tgt1", 8'hC3);

    // cmd_reset request
`ifdef JTAG_MASTER_RESET_CMD_EN
    do_scan(1'b1, 1'b1, 8'h77, 8'h11, 1'b0, ntck);
    check("rcmd_tck", 64'(ntck), 64'd6);
    check("rcmd_tms", last_n(tms_hist, 6), 64'h3E);
    check("rcmd_tgt_none", 64'(tgt_in_q.size()), 64'd0);
`else
    exp_q.push_back(8'h11);
    do_scan(1'b1, 1'b1, 8'h77, 8'h11, 1'b0, ntck);
    check("rcmd_tck", 64'(ntck), 64'd14);
    check("rcmd_tms", last_n(tms_hist, 14), 64'h3006);
    check_tgt("rcmd_tgt", 8'h77);
`endif
    check("rcmd_tap", 64'(tap), 64'(RTI));

    // Reset asserted during shift bit 4 of an IR scan
    tgt_pattern = 8'h00;
    exp_q.push_back(8'h00);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_ir = 1'b1; cmd_data = 8'hFF;
    t0 = tck_total;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < 500; k++) begin
      if (tck_total - t0 >= 9) break;
      @(negedge clk);
    end
    check("abort_reached", 64'(tck_total - t0), 64'd9);
    reset = 1'b1;
    #1;
    exp_q.delete();
    check("abort_tck", {63'd0, tck}, 64'd0);
    check("abort_tms", {63'd0, tms}, 64'd1);
    check("abort_ready", {63'd0, cmd_ready}, 64'd0);
    check("abort_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    repeat (3) @(negedge clk);
    t0 = tck_total;
    reset = 1'b0;
    wait_ready(cyc);
    check("abort_ready_cycles", 64'(cyc), 64'd24);
    check("abort_rstseq_tck", 64'(tck_total - t0), 64'd6);
    check("abort_rstseq_tms", last_n(tms_hist, 6), 64'h3E);
    check("abort_tap", 64'(tap), 64'(RTI));
    tgt_in_q.delete();

    repeat (4) @(negedge clk);
    check("scoreboard_drain", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
